// File: rtl/ins_fetch_responder_if.sv
// rtl/ins_fetch_responder_if.sv - fetch handshake and shared RAM port bundle
//
// Purpose: groups the instruction-fetch request/done handshake with the
// byte-wide RAM port (arbiter req/grant, address, read data, write enable).
//
// Signals:
//   request_ins_from_memory_adaptor            icache -> responder, level request
//   insaddr_to_be_fetched_from_memory_adaptor  icache -> responder, byte address
//   ins_fetched_from_memory_adaptor            responder -> icache, {b3,b2,b1,b0}
//   insfetch_task_done                         responder -> icache, one-cycle pulse
//   bus_req                                    responder -> arbiter
//   bus_grant                                  arbiter -> responder
//   mem_din                                    RAM -> responder, valid cycle after mem_a
//   mem_a                                      responder -> RAM, byte address
//   mem_wr                                     responder -> RAM, always 0
//
// Modports:
//   slave  - the responder (memory side)
//   master - the icache / arbiter / RAM side
interface ins_fetch_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  request_ins_from_memory_adaptor;
  logic [ADDR_WIDTH-1:0] insaddr_to_be_fetched_from_memory_adaptor;
  logic [31:0]           ins_fetched_from_memory_adaptor;
  logic                  insfetch_task_done;
  logic                  bus_req;
  logic                  bus_grant;
  logic [7:0]            mem_din;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport slave (
    input  request_ins_from_memory_adaptor,
    input  insaddr_to_be_fetched_from_memory_adaptor,
    output ins_fetched_from_memory_adaptor,
    output insfetch_task_done,
    output bus_req,
    input  bus_grant,
    input  mem_din,
    output mem_a,
    output mem_wr
  );

  modport master (
    output request_ins_from_memory_adaptor,
    output insaddr_to_be_fetched_from_memory_adaptor,
    input  ins_fetched_from_memory_adaptor,
    input  insfetch_task_done,
    input  bus_req,
    output bus_grant,
    output mem_din,
    input  mem_a,
    input  mem_wr
  );
endinterface

// File: rtl/ins_fetch_responder.sv
// rtl/ins_fetch_responder.sv - memory-side responder for instruction fetches
//
// Purpose: accepts a fetch address from the icache, reads four consecutive
// bytes from the shared byte-wide synchronous RAM (through a req/grant
// arbiter), assembles them little-endian and returns the word with a
// one-cycle done pulse.
//
// Ports:
//   clk_in         system clock
//   rst_in         asynchronous, active-low reset
//   rdy_in         global ready; low pauses the block
//   flush_pipline  abort any in-flight fetch
//   bus            ins_fetch_responder_if.slave: fetch handshake + RAM port
module ins_fetch_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_BYTES = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_pipline,
  ins_fetch_responder_if.slave bus
);

  localparam logic [2:0] NUM_BYTES = 3'(FETCH_BYTES);
  localparam logic [2:0] LAST_BYTE = 3'(FETCH_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  // issue_q: next byte index to present; capt_q: bytes already captured.
  logic [2:0]            issue_q, issue_d;
  logic [2:0]            capt_q, capt_d;
  // pending_q: the address presented last cycle was accepted by the RAM,
  // so its byte is on mem_din this cycle.
  logic                  pending_q, pending_d;
  logic [23:0]           low_q, low_d;
  logic [31:0]           word_q, word_d;

  logic                  stall;
  logic [1:0]            byte_sel;
  logic                  bus_req_c;
  logic                  done_c;
  logic [ADDR_WIDTH-1:0] mem_a_c;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    issue_d   = issue_q;
    capt_d    = capt_q;
    pending_d = pending_q;
    low_d     = low_q;
    word_d    = word_q;
    bus_req_c = 1'b0;
    done_c    = 1'b0;
    mem_a_c   = '0;

    stall = !rdy_in || !bus.bus_grant;
    // Once all four addresses are issued, keep pointing at the last byte
    // rather than running past the fetch window.
    byte_sel = (issue_q > LAST_BYTE) ? 2'd3 : issue_q[1:0];

    case (state_q)
      ST_IDLE: begin
        // Gated by rst_in so the arbiter sees no request while in reset.
        bus_req_c = rst_in && bus.request_ins_from_memory_adaptor && !flush_pipline;
        if (rdy_in && bus.request_ins_from_memory_adaptor &&
            bus.bus_grant && !flush_pipline) begin
          state_d   = ST_FETCH;
          base_d    = bus.insaddr_to_be_fetched_from_memory_adaptor;
          issue_d   = 3'd0;
          capt_d    = 3'd0;
          pending_d = 1'b0;
        end
      end

      ST_FETCH: begin
        bus_req_c = 1'b1;
        mem_a_c   = base_q + ADDR_WIDTH'(byte_sel);
        if (stall) begin
          // The byte in flight is discarded; rewinding the issue pointer
          // re-presents the oldest byte still missing.
          issue_d   = capt_q;
          pending_d = 1'b0;
        end else begin
          if (pending_q) begin
            if (capt_q == LAST_BYTE) begin
              word_d  = {bus.mem_din, low_q};
              state_d = ST_DONE;
            end else begin
              low_d[{capt_q[1:0], 3'b000} +: 8] = bus.mem_din;
            end
            capt_d = capt_q + 3'd1;
          end
          if (issue_q < NUM_BYTES) begin
            issue_d   = issue_q + 3'd1;
            pending_d = 1'b1;
          end else begin
            pending_d = 1'b0;
          end
        end
      end

      ST_DONE: begin
        done_c = 1'b1;
        if (rdy_in) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush overrides everything, but only on an edge where the block runs.
    if (rdy_in && flush_pipline) begin
      state_d   = ST_IDLE;
      issue_d   = 3'd0;
      capt_d    = 3'd0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      issue_q   <= 3'd0;
      capt_q    <= 3'd0;
      pending_q <= 1'b0;
      low_q     <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      issue_q   <= issue_d;
      capt_q    <= capt_d;
      pending_q <= pending_d;
      low_q     <= low_d;
      word_q    <= word_d;
    end
  end

  assign bus.ins_fetched_from_memory_adaptor = word_q;
  assign bus.insfetch_task_done              = done_c;
  assign bus.bus_req                         = bus_req_c;
  assign bus.mem_a                           = mem_a_c;
  assign bus.mem_wr                          = 1'b0;

endmodule

// File: tb/tb_ins_fetch_responder.sv
// tb/tb_ins_fetch_responder.sv - self-checking bench for ins_fetch_responder
module tb_ins_fetch_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_pipline;
  logic        req;
  logic [31:0] addr;
  logic        grant;

  int n_checks = 0;
  int n_fail   = 0;

  ins_fetch_responder_if #(.ADDR_WIDTH(32)) bus ();

  assign bus.request_ins_from_memory_adaptor           = req;
  assign bus.insaddr_to_be_fetched_from_memory_adaptor = addr;
  assign bus.bus_grant                                 = grant;

  ins_fetch_responder #(.ADDR_WIDTH(32), .FETCH_BYTES(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_pipline (flush_pipline),
    .bus           (bus)
  );

  always #5 clk_in = ~clk_in;

  // RAM contents: a few fixed bytes, a hash of the address elsewhere.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [7:0] h;
    case (a)
      32'h0000_0100: h = 8'h13;
      32'h0000_0101: h = 8'h05;
      32'h0000_0102: h = 8'hA0;
      32'h0000_0103: h = 8'h00;
      default: begin
        h = a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
        h = h * 8'd29 + 8'h3B;
      end
    endcase
    return h;
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] b);
    return {ram_byte(b + 32'd3), ram_byte(b + 32'd2), ram_byte(b + 32'd1), ram_byte(b)};
  endfunction

  // Synchronous-read RAM: data for the address seen at an edge appears after it.
  always @(posedge clk_in) bus.mem_din <= ram_byte(bus.mem_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. A fetch progresses in "runs" of non-stalled cycles:
  // within a run started with g bytes captured, the k-th cycle presents byte
  // g+k (capped at the last byte) and k advancing edges have captured
  // g+k-1 bytes. A stall ends the run and the next one starts from what was
  // actually captured.
  typedef enum {M_IDLE, M_FETCH, M_DONE} mstate_t;
  mstate_t     m_state = M_IDLE;
  logic [31:0] m_base  = '0;
  logic [31:0] m_word  = '0;
  int          m_start = 0;
  int          m_pos   = 0;

  function automatic int m_got();
    return m_start + ((m_pos > 0) ? m_pos - 1 : 0);
  endfunction

  function automatic logic [31:0] m_addr();
    int idx;
    idx = m_start + m_pos;
    if (idx > 3) idx = 3;
    return m_base + 32'(idx);
  endfunction

  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        chk("reset bus_req", {31'd0, bus.bus_req}, 32'd0);
        chk("reset done", {31'd0, bus.insfetch_task_done}, 32'd0);
        chk("reset mem_a", bus.mem_a, 32'd0);
        chk("reset ins", bus.ins_fetched_from_memory_adaptor, 32'd0);
        m_state = M_IDLE;
        m_start = 0;
        m_pos   = 0;
      end else begin
        chk("mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        case (m_state)
          M_IDLE: begin
            chk("idle bus_req", {31'd0, bus.bus_req}, {31'd0, req & ~flush_pipline});
            chk("idle done", {31'd0, bus.insfetch_task_done}, 32'd0);
          end
          M_FETCH: begin
            chk("fetch bus_req", {31'd0, bus.bus_req}, 32'd1);
            chk("fetch done", {31'd0, bus.insfetch_task_done}, 32'd0);
            chk("fetch mem_a", bus.mem_a, m_addr());
          end
          default: begin
            chk("done pulse", {31'd0, bus.insfetch_task_done}, 32'd1);
            chk("done bus_req", {31'd0, bus.bus_req}, 32'd0);
            chk("done word", bus.ins_fetched_from_memory_adaptor, m_word);
          end
        endcase

        // Advance the model across the coming edge.
        if (!rdy_in) begin
          if (m_state == M_FETCH) begin
            m_start = m_got();
            m_pos   = 0;
          end
        end else if (flush_pipline) begin
          m_state = M_IDLE;
        end else begin
          case (m_state)
            M_IDLE: begin
              if (req && grant) begin
                m_state = M_FETCH;
                m_base  = addr;
                m_start = 0;
                m_pos   = 0;
              end
            end
            M_FETCH: begin
              if (!grant) begin
                m_start = m_got();
                m_pos   = 0;
              end else begin
                m_pos++;
                if (m_got() == 4) begin
                  m_state = M_DONE;
                  m_word  = expect_word(m_base);
                end
              end
            end
            default: m_state = M_IDLE;
          endcase
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      next_cycle();
      if (bus.insfetch_task_done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  logic [31:0] seen_a [4];

  // Request at cycle 0 with grant and ready held high; checks addresses in
  // cycles 1-4 and the done pulse in cycle 6.
  task automatic fetch_seq(input string tag, input logic [31:0] a, input logic [31:0] exp_word);
    int cyc;
    next_cycle();
    req = 1'b1; addr = a; grant = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      seen_a[c] = bus.mem_a;
      chk({tag, " mem_a"}, bus.mem_a, a + 32'(c));
      chk({tag, " early done"}, {31'd0, bus.insfetch_task_done}, 32'd0);
    end
    wait_done(6, cyc);
    chk({tag, " done cycle"}, 32'(cyc), 32'd2);
    chk({tag, " word"}, bus.ins_fetched_from_memory_adaptor, exp_word);
    next_cycle();
    req = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic had_req;
    logic saw_done;
    logic last_flush_eff;

    rst_in = 1'b0; rdy_in = 1'b1; flush_pipline = 1'b0;
    req = 1'b0; addr = '0; grant = 1'b1;
    repeat (3) @(posedge clk_in);
    #2;
    rst_in = 1'b1;

    fetch_seq("basic", 32'h0000_0100, 32'h00A0_0513);

    fetch_seq("wrap", 32'hFFFF_FFFE, expect_word(32'hFFFF_FFFE));
    chk("wrap third addr", seen_a[2], 32'h0000_0000);
    chk("wrap fourth addr", seen_a[3], 32'h0000_0001);

    // Stall for two cycles right after byte 1 is captured.
    next_cycle();
    req = 1'b1; addr = 32'h0000_0300;
    repeat (3) next_cycle();
    next_cycle();
    rdy_in = 1'b0;
    next_cycle();
    chk("stall re-present", bus.mem_a, 32'h0000_0302);
    next_cycle();
    rdy_in = 1'b1;
    chk("stall resume addr", bus.mem_a, 32'h0000_0302);
    wait_done(10, cyc);
    chk("stall done cycle", 32'(cyc), 32'd3);
    chk("stall word", bus.ins_fetched_from_memory_adaptor, expect_word(32'h0000_0300));
    next_cycle();
    req = 1'b0;

    // Grant withheld until cycle 5.
    next_cycle();
    req = 1'b1; addr = 32'h0000_0500; grant = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      chk("nogrant bus_req", {31'd0, bus.bus_req}, 32'd1);
      chk("nogrant done", {31'd0, bus.insfetch_task_done}, 32'd0);
    end
    next_cycle();
    grant = 1'b1;
    wait_done(10, cyc);
    chk("grant done cycle", 32'(cyc), 32'd6);
    chk("grant word", bus.ins_fetched_from_memory_adaptor, expect_word(32'h0000_0500));
    next_cycle();
    req = 1'b0;

    // Flush in cycle 3, new request for 0x200 in cycle 4.
    next_cycle();
    req = 1'b1; addr = 32'h0000_0100;
    repeat (2) next_cycle();
    next_cycle();
    flush_pipline = 1'b1;
    next_cycle();
    flush_pipline = 1'b0; addr = 32'h0000_0200;
    wait_done(10, cyc);
    chk("flush refetch done cycle", 32'(cyc), 32'd6);
    chk("flush refetch word", bus.ins_fetched_from_memory_adaptor, expect_word(32'h0000_0200));
    next_cycle();
    req = 1'b0;

    // Asynchronous reset between edges in the middle of a fetch.
    next_cycle();
    req = 1'b1; addr = 32'h0000_0400;
    repeat (2) next_cycle();
    rst_in = 1'b0;
    #1;
    chk("async reset mem_a", bus.mem_a, 32'd0);
    chk("async reset bus_req", {31'd0, bus.bus_req}, 32'd0);
    chk("async reset done", {31'd0, bus.insfetch_task_done}, 32'd0);
    chk("async reset ins", bus.ins_fetched_from_memory_adaptor, 32'd0);
    req = 1'b0;
    next_cycle();
    rst_in = 1'b1;
    fetch_seq("post-reset", 32'h0000_0100, 32'h00A0_0513);

    // Randomised traffic: legal requester, random ready/grant/flush.
    saw_done = 1'b0;
    last_flush_eff = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      had_req = req;
      if (bus.insfetch_task_done === 1'b1) begin
        saw_done = 1'b1;
      end else if (saw_done) begin
        req = 1'b0;
        saw_done = 1'b0;
      end
      if (last_flush_eff) req = 1'b0;
      if (!had_req && $urandom_range(0, 3) == 0) begin
        req = 1'b1;
        if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        else addr = $urandom;
      end
      rdy_in        = ($urandom_range(0, 9) != 0);
      grant         = ($urandom_range(0, 4) != 0);
      flush_pipline = ($urandom_range(0, 29) == 0);
      last_flush_eff = flush_pipline && rdy_in;
    end

    next_cycle();
    req = 1'b0; flush_pipline = 1'b0; rdy_in = 1'b1; grant = 1'b1;
    repeat (10) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
